// File: rtl/onchip_mem_arbiter_2m_pkg.sv
// Shared types and default widths for the two-master on-chip RAM arbiter.
package onchip_mem_arb_pkg;

  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_BE_W   = 4;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } mst_idx_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_BE_W-1:0]   be;
    logic                  rd;
    logic                  wr;
    logic [DEF_DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/onchip_mem_arbiter_2m_chk.sv
// Protocol checks for the arbiter's master ports and read-return path.
module onchip_mem_arbiter_2m_chk (
  input logic clk,
  input logic reset,
  input logic m0_read,
  input logic m0_write,
  input logic m1_read,
  input logic m1_write,
  input logic m0_readdatavalid,
  input logic m1_readdatavalid
);

  a_m0_rd_wr_excl: assert property (@(posedge clk) disable iff (reset) !(m0_read && m0_write));
  a_m1_rd_wr_excl: assert property (@(posedge clk) disable iff (reset) !(m1_read && m1_write));
  a_rdv_excl:      assert property (@(posedge clk) !(m0_readdatavalid && m1_readdatavalid));

endmodule

// File: rtl/onchip_mem_arbiter_2m_rr_arb2.sv
// Two-way round-robin arbiter; last_q remembers the most recent winner.
module rr_arb2
  import onchip_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  mst_idx_e last_q;
  mst_idx_e win_s;

  // Winner selection: a lone requester wins, contention goes to the non-last master.
  always_comb begin
    gnt   = 2'b00;
    win_s = last_q;
    case (req)
      2'b01: begin
        gnt   = 2'b01;
        win_s = M0;
      end
      2'b10: begin
        gnt   = 2'b10;
        win_s = M1;
      end
      2'b11: begin
        if (last_q == M0) begin
          gnt   = 2'b10;
          win_s = M1;
        end else begin
          gnt   = 2'b01;
          win_s = M0;
        end
      end
      default: begin
        gnt   = 2'b00;
        win_s = last_q;
      end
    endcase
  end

  assign gnt_idx = win_s;

  // Pointer register; reset to M1 so M0 takes the first contended cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= M1;
    end else if (|req) begin
      last_q <= win_s;
    end else begin
      last_q <= last_q;
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter_2m.sv
// Shares one single-port RAM between two Avalon-MM masters with round-robin
// grant and a one-cycle read-return pipeline routed back to the issuing master.
module onchip_mem_arbiter_2m
  import onchip_mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BE_W   = DEF_BE_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  output logic              mem_reset_req,
  input  logic [DATA_W-1:0] mem_readdata
);

  if (RD_LAT != 1) begin : g_bad_lat
    $error("onchip_mem_arbiter_2m: only RD_LAT=1 is supported");
  end
  if (ADDR_W != DEF_ADDR_W || DATA_W != DEF_DATA_W || BE_W != DEF_BE_W) begin : g_bad_w
    $error("onchip_mem_arbiter_2m: widths must match the request struct");
  end

  mem_req_t [1:0] req_s;
  mem_req_t       win_s;
  logic [1:0]     req_vec_s;
  logic [1:0]     gnt_s;
  logic           gnt_idx_s;
  logic           accept_s;
  logic           rd_vld_q;
  mst_idx_e       rd_own_q;

  // Read and write together is treated as a write.
  always_comb begin
    req_s[0]  = '{addr: m0_address, be: m0_byteenable, rd: m0_read & ~m0_write,
                  wr: m0_write, wdata: m0_writedata};
    req_s[1]  = '{addr: m1_address, be: m1_byteenable, rd: m1_read & ~m1_write,
                  wr: m1_write, wdata: m1_writedata};
    req_vec_s = {m1_read | m1_write, m0_read | m0_write};
  end

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_vec_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s)
  );

  // Winner mux onto the RAM port; nothing is accepted while reset is high.
  always_comb begin
    accept_s       = (|gnt_s) & ~reset;
    win_s          = req_s[gnt_idx_s];
    m0_waitrequest = ~(accept_s & gnt_s[0]);
    m1_waitrequest = ~(accept_s & gnt_s[1]);
    mem_chipselect = accept_s;
    mem_write      = accept_s & win_s.wr;
    mem_address    = win_s.addr;
    mem_byteenable = win_s.be;
    mem_writedata  = win_s.wdata;
    mem_clken      = 1'b1;
    mem_reset_req  = 1'b0;
  end

  // Read-return tracking: one outstanding slot per cycle, matching RAM latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_vld_q <= 1'b0;
      rd_own_q <= M0;
    end else begin
      rd_vld_q <= accept_s & win_s.rd;
      rd_own_q <= mst_idx_e'(gnt_idx_s);
    end
  end

  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_vld_q & (rd_own_q == M0);
  assign m1_readdatavalid = rd_vld_q & (rd_own_q == M1);

  onchip_mem_arbiter_2m_chk u_chk (
    .clk              (clk),
    .reset            (reset),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_readdatavalid (m1_readdatavalid)
  );

endmodule
